tt_dfd_generic_pidtovid: RTL and testbench
==========================================

Name: tt_dfd_generic_pidtovid

Overview:
- Registered physical-ID to virtual-ID translator for debug/trace fabrics: maps hart PIDs back to their software-visible VIDs.
- Builds a PID-indexed table from the fuse map and VID map in a sequential build pass, one hart per cycle, and flags mapping conflicts.
- Serves single-PID lookups over a valid/ready handshake.
- Re-indexes per-hart status vectors from PID order to VID order.

Parameters:
- NumHarts, 8, number of physical harts.
- NumHartsIdx, (NumHarts==1)?1:$clog2(NumHarts), ID width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cfg_load  in  1  pulse: capture fuse_map/vid_map and rebuild table
- fuse_map  in  NumHarts  bit p=1: PID p present
- vid_map  in  NumHarts x NumHartsIdx  VID assigned to each PID
- cfg_busy  out  1  table build in progress
- cfg_done  out  1  one-cycle pulse at build completion
- cfg_err  out  1  sticky: duplicate or out-of-range VID seen in last build
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when valid&ready
- req_pid  in  NumHartsIdx  PID to translate
- rsp_valid  out  1  one-cycle lookup response
- rsp_vid  out  NumHartsIdx  translated VID (0 if unmapped)
- rsp_mapped  out  1  1: PID is fused and mapped
- pid_vector  in  NumHarts  status indexed by PID
- vid_vector  out  NumHarts  same status indexed by VID, registered

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; table entries, vid_used and shadow registers cleared.
  - All outputs reset to 0.
- States: IDLE, BUILD, READY.
- cfg_load:
  - In IDLE or READY: shadow fuse_map/vid_map are captured, table and vid_used are cleared, index=0, state goes to BUILD.
  - In BUILD: ignored.
- BUILD, one hart per cycle for index i = 0..NumHarts-1:
  - If shadow_fuse[i] and v = shadow_vid[i] < NumHarts and !vid_used[v]: entry[i] = {vid=v, mapped=1}; vid_used[v] set.
  - If shadow_fuse[i] and the VID is a duplicate or >= NumHarts: entry[i] stays unmapped and cfg_err is set.
  - Unfused harts stay unmapped.
  - On i = NumHarts-1: state goes to READY and cfg_done pulses the following cycle.
  - Build takes exactly NumHarts cycles; the first fused PID claiming a VID wins.
- cfg_busy = (state==BUILD).
- cfg_err is cleared on an accepted cfg_load and held otherwise.
- Lookup:
  - req_ready = (state==READY).
  - Accept on req_valid & req_ready. The response registers update on the next clock edge, so rsp_valid is high for exactly one cycle in the cycle after acceptance.
  - rsp_vid = entry[req_pid].vid and rsp_mapped = entry[req_pid].mapped.
  - req_pid >= NumHarts: rsp_mapped=0, rsp_vid=0.
  - Back-to-back requests are accepted every cycle, throughput 1.
  - A request and cfg_load in the same READY cycle: the request is accepted and answered from the old table; the next cycle is BUILD with req_ready=0.
  - req_valid while not ready is not accepted (rsp_valid stays 0); the requester holds the request.
- Vector path:
  - Registered, latency 1.
  - In READY: vid_vector[entry[p].vid] = pid_vector[p] for every mapped p; all other bits are 0.
  - Outside READY: vid_vector = 0.
- Reset mid-BUILD aborts the build and returns to IDLE with the table empty. There is no resume.

Decomposition:
- Shared package tt_dfd_vid_pkg holds:
  - the entry struct {vid, mapped};
  - the state enum {IDLE, BUILD, READY}.
- NumHartsIdx derivation is parameterised at the module.
- No sub-module; the table and FSM stay in one module.

Test Plan:
- NumHarts=8, reset released, no cfg_load:
  - req_ready=0 and vid_vector=0.
  - cfg_err, cfg_done and rsp_valid stay 0.
- Load fuse=8'hFF, vid_map = reverse (PID p -> VID 7-p):
  - cfg_busy high for exactly 8 cycles, then cfg_done pulses and cfg_err=0.
  - req_pid=2 gives rsp_vid=5, rsp_mapped=1, one cycle after acceptance.
- Load fuse=8'h0F, PID0..3 -> VID 0..3:
  - req_pid=6 gives rsp_mapped=0, rsp_vid=0.
  - pid_vector=8'hFF gives vid_vector=8'h0F one cycle later.
- Load fuse=8'h03, PID0 and PID1 both -> VID 4:
  - cfg_err=1.
  - PID0 gives VID 4 mapped; PID1 gives unmapped.
- READY with the reverse map, req_pid=1 and cfg_load asserted in the same cycle:
  - Response VID 6 comes from the old table.
  - Next cycle req_ready=0 and cfg_busy=1.
  - cfg_load pulsed during BUILD is ignored (build length stays 8).
- Assert reset_n=0 mid-BUILD:
  - All outputs 0 immediately (asynchronous).
  - After release, state is IDLE and req_ready=0 until a new load completes.

Source files
------------

// File: rtl/tt_dfd_vid_pkg.sv
// Shared types for the PID-to-VID translator: table entry layout and FSM states.
package tt_dfd_vid_pkg;

  // Widest VID an entry can hold; entries zero-extend narrower IDs into it.
  localparam int unsigned VidMaxW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    READY = 2'd2
  } pidtovid_state_e;

  typedef struct packed {
    logic [VidMaxW-1:0] vid;
    logic               mapped;
  } pid_entry_t;

endpackage

// File: rtl/tt_dfd_generic_pidtovid.sv
// Physical-ID to virtual-ID translator: builds a PID-indexed table one hart per
// cycle, answers single-PID lookups and re-indexes a status vector into VID order.
module tt_dfd_generic_pidtovid
  import tt_dfd_vid_pkg::*;
#(
  parameter int unsigned NumHarts    = 8,
  parameter int unsigned NumHartsIdx = (NumHarts == 1) ? 1 : $clog2(NumHarts)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 cfg_load,
  input  logic [NumHarts-1:0]                  fuse_map,
  input  logic [NumHarts-1:0][NumHartsIdx-1:0] vid_map,
  output logic                                 cfg_busy,
  output logic                                 cfg_done,
  output logic                                 cfg_err,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [NumHartsIdx-1:0]               req_pid,
  output logic                                 rsp_valid,
  output logic [NumHartsIdx-1:0]               rsp_vid,
  output logic                                 rsp_mapped,
  input  logic [NumHarts-1:0]                  pid_vector,
  output logic [NumHarts-1:0]                  vid_vector
);

  pidtovid_state_e                      state_q, state_d;
  logic [NumHartsIdx-1:0]               idx_q, idx_d;
  logic [NumHarts-1:0]                  shadow_fuse_q, shadow_fuse_d;
  logic [NumHarts-1:0][NumHartsIdx-1:0] shadow_vid_q, shadow_vid_d;
  pid_entry_t                           entry_q [NumHarts];
  pid_entry_t                           entry_d [NumHarts];
  logic [NumHarts-1:0]                  vid_used_q, vid_used_d;
  logic                                 cfg_err_q, cfg_err_d;
  logic                                 cfg_done_q, cfg_done_d;
  logic                                 rsp_valid_q, rsp_valid_d;
  logic [NumHartsIdx-1:0]               rsp_vid_q, rsp_vid_d;
  logic                                 rsp_mapped_q, rsp_mapped_d;
  logic [NumHarts-1:0]                  vid_vector_q, vid_vector_d;

  logic [NumHartsIdx-1:0]               cur_vid;
  logic                                 req_accept;
  pid_entry_t                           lk_entry;

  // Table build FSM: one hart per cycle, lowest fused PID claims a VID first.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_fuse_d = shadow_fuse_q;
    shadow_vid_d  = shadow_vid_q;
    entry_d       = entry_q;
    vid_used_d    = vid_used_q;
    cfg_err_d     = cfg_err_q;
    cfg_done_d    = 1'b0;
    cur_vid       = shadow_vid_q[idx_q];

    unique case (state_q)
      IDLE, READY: begin
        if (cfg_load) begin
          shadow_fuse_d = fuse_map;
          shadow_vid_d  = vid_map;
          entry_d       = '{default: '0};
          vid_used_d    = '0;
          cfg_err_d     = 1'b0;
          idx_d         = '0;
          state_d       = BUILD;
        end
      end
      BUILD: begin
        if (shadow_fuse_q[idx_q]) begin
          if ((32'(cur_vid) < NumHarts) && !vid_used_q[cur_vid]) begin
            entry_d[idx_q].vid    = VidMaxW'(cur_vid);
            entry_d[idx_q].mapped = 1'b1;
            vid_used_d[cur_vid]   = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (32'(idx_q) == NumHarts - 1) begin
          state_d    = READY;
          cfg_done_d = 1'b1;
        end else begin
          idx_d = idx_q + NumHartsIdx'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lookups are answered from the table as it stands at acceptance.
  assign req_accept = req_valid && (state_q == READY);

  always_comb begin
    lk_entry     = '0;
    rsp_valid_d  = req_accept;
    rsp_vid_d    = rsp_vid_q;
    rsp_mapped_d = rsp_mapped_q;
    if (32'(req_pid) < NumHarts) begin
      lk_entry = entry_q[req_pid];
    end
    if (req_accept) begin
      rsp_mapped_d = lk_entry.mapped;
      rsp_vid_d    = lk_entry.mapped ? lk_entry.vid[NumHartsIdx-1:0] : '0;
    end
  end

  // VID-ordered status: each VID bit collects the status of the PID that owns it.
  always_comb begin
    vid_vector_d = '0;
    if (state_q == READY) begin
      for (int v = 0; v < NumHarts; v++) begin
        for (int p = 0; p < NumHarts; p++) begin
          if (entry_q[p].mapped && (entry_q[p].vid == VidMaxW'(v))) begin
            vid_vector_d[v] = vid_vector_d[v] | pid_vector[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      shadow_fuse_q <= '0;
      shadow_vid_q  <= '0;
      entry_q       <= '{default: '0};
      vid_used_q    <= '0;
      cfg_err_q     <= 1'b0;
      cfg_done_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_vid_q     <= '0;
      rsp_mapped_q  <= 1'b0;
      vid_vector_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_fuse_q <= shadow_fuse_d;
      shadow_vid_q  <= shadow_vid_d;
      entry_q       <= entry_d;
      vid_used_q    <= vid_used_d;
      cfg_err_q     <= cfg_err_d;
      cfg_done_q    <= cfg_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_vid_q     <= rsp_vid_d;
      rsp_mapped_q  <= rsp_mapped_d;
      vid_vector_q  <= vid_vector_d;
    end
  end

  assign cfg_busy   = (state_q == BUILD);
  assign req_ready  = (state_q == READY);
  assign cfg_done   = cfg_done_q;
  assign cfg_err    = cfg_err_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_vid    = rsp_vid_q;
  assign rsp_mapped = rsp_mapped_q;
  assign vid_vector = vid_vector_q;

endmodule

// File: tb/tb_tt_dfd_generic_pidtovid.sv
// Randomised bench for the PID-to-VID translator against a table-level reference model.
module tb_tt_dfd_generic_pidtovid;

  localparam int N = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_load = 1'b0;
  logic [N-1:0]      fuse_map = '0;
  logic [N-1:0][2:0] vid_map = '0;
  logic              cfg_busy, cfg_done, cfg_err;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_pid = '0;
  logic              rsp_valid;
  logic [2:0]        rsp_vid;
  logic              rsp_mapped;
  logic [N-1:0]      pid_vector = '0;
  logic [N-1:0]      vid_vector;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference table derived directly from the mapping rules.
  bit       m_mapped [N];
  int       m_vid    [N];
  bit       m_err;

  tt_dfd_generic_pidtovid #(.NumHarts(N)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load),
    .fuse_map(fuse_map), .vid_map(vid_map),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_pid(req_pid),
    .rsp_valid(rsp_valid), .rsp_vid(rsp_vid), .rsp_mapped(rsp_mapped),
    .pid_vector(pid_vector), .vid_vector(vid_vector)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_model(input logic [N-1:0] f, input logic [N-1:0][2:0] vm);
    bit used [N];
    for (int i = 0; i < N; i++) begin
      used[i] = 0; m_mapped[i] = 0; m_vid[i] = 0;
    end
    m_err = 0;
    for (int p = 0; p < N; p++) begin
      if (f[p]) begin
        if (int'(vm[p]) < N && !used[vm[p]]) begin
          m_mapped[p] = 1; m_vid[p] = int'(vm[p]); used[vm[p]] = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] model_vec(input logic [N-1:0] pv);
    logic [N-1:0] r = '0;
    for (int p = 0; p < N; p++)
      if (m_mapped[p]) r[m_vid[p]] = pv[p];
    return r;
  endfunction

  // Called at a negedge while IDLE or READY; returns at the negedge after cfg_done.
  task automatic do_load(input logic [N-1:0] f, input logic [N-1:0][2:0] vm);
    int cnt;
    build_model(f, vm);
    fuse_map = f; vid_map = vm; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    fuse_map = N'($urandom);
    vid_map  = 24'($urandom);
    cnt = 0;
    while (cfg_busy === 1'b1 && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, N);
    chk("cfg_done", {31'b0, cfg_done}, 1);
    chk("cfg_err", {31'b0, cfg_err}, {31'b0, m_err});
    chk("req_ready_after_build", {31'b0, req_ready}, 1);
    @(negedge clk);
    chk("cfg_done_pulse_end", {31'b0, cfg_done}, 0);
    $display("[TB] load fuse=%02h map=%06h busy=%0d err=%0b", f, vm, cnt, cfg_err);
  endtask

  task automatic lookup1(input logic [2:0] pid, input int exp_vid, input bit exp_map);
    req_valid = 1'b1; req_pid = pid;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_valid", {31'b0, rsp_valid}, 1);
    chk("rsp_vid", {29'b0, rsp_vid}, exp_vid);
    chk("rsp_mapped", {31'b0, rsp_mapped}, {31'b0, exp_map});
    $display("[TB] lookup pid=%0d -> vid=%0d mapped=%0b", pid, rsp_vid, rsp_mapped);
  endtask

  task automatic run_lookups(input int n);
    logic [2:0] pid_prev;
    req_valid = 1'b1;
    req_pid = 3'($urandom_range(0, N - 1));
    for (int i = 0; i < n; i++) begin
      pid_prev = req_pid;
      @(negedge clk);
      chk("b2b_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("b2b_rsp_vid", {29'b0, rsp_vid}, m_vid[pid_prev]);
      chk("b2b_rsp_mapped", {31'b0, rsp_mapped}, {31'b0, m_mapped[pid_prev]});
      req_pid = 3'($urandom_range(0, N - 1));
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("rsp_valid_idle", {31'b0, rsp_valid}, 0);
  endtask

  task automatic run_vectors(input int n);
    logic [N-1:0] pv;
    for (int i = 0; i < n; i++) begin
      pv = N'($urandom);
      pid_vector = pv;
      @(negedge clk);
      chk("vid_vector", {24'b0, vid_vector}, {24'b0, model_vec(pv)});
    end
  endtask

  logic [N-1:0][2:0] vm_t;
  int                cnt;

  initial begin
    // Reset state and no load.
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pid_vector = 8'hFF;
    req_valid = 1'b1; req_pid = 3'd2;
    repeat (3) @(negedge clk);
    chk("idle_req_ready", {31'b0, req_ready}, 0);
    chk("idle_vid_vector", {24'b0, vid_vector}, 0);
    chk("idle_cfg_err", {31'b0, cfg_err}, 0);
    chk("idle_cfg_done", {31'b0, cfg_done}, 0);
    chk("idle_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("idle_cfg_busy", {31'b0, cfg_busy}, 0);
    req_valid = 1'b0;

    // Reverse map, all fused.
    for (int p = 0; p < N; p++) vm_t[p] = 3'(N - 1 - p);
    do_load(8'hFF, vm_t);
    lookup1(3'd2, 5, 1'b1);
    run_vectors(4);

    // Lower four harts, identity map.
    for (int p = 0; p < N; p++) vm_t[p] = 3'(p);
    do_load(8'h0F, vm_t);
    lookup1(3'd6, 0, 1'b0);
    pid_vector = 8'hFF;
    @(negedge clk);
    chk("vec_0f", {24'b0, vid_vector}, 32'h0F);

    // Duplicate VID: first PID wins.
    vm_t = '0; vm_t[0] = 3'd4; vm_t[1] = 3'd4;
    do_load(8'h03, vm_t);
    lookup1(3'd0, 4, 1'b1);
    lookup1(3'd1, 0, 1'b0);

    // Request and cfg_load together in READY.
    for (int p = 0; p < N; p++) vm_t[p] = 3'(N - 1 - p);
    do_load(8'hFF, vm_t);
    req_valid = 1'b1; req_pid = 3'd1; cfg_load = 1'b1;
    fuse_map = 8'h01; vid_map = '0;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("same_cycle_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("same_cycle_rsp_vid", {29'b0, rsp_vid}, 6);
    chk("same_cycle_req_ready", {31'b0, req_ready}, 0);
    chk("same_cycle_busy", {31'b0, cfg_busy}, 1);
    build_model(8'h01, '0);
    cnt = 1;
    @(negedge clk);
    chk("held_req_not_accepted", {31'b0, rsp_valid}, 0);
    req_valid = 1'b0;
    while (cfg_busy === 1'b1 && cnt < 64) begin
      cnt++;
      cfg_load = (cnt == 3);
      fuse_map = 8'hFF;
      @(negedge clk);
    end
    cfg_load = 1'b0;
    chk("busy_with_ignored_load", cnt, N);
    chk("done_after_ignored_load", {31'b0, cfg_done}, 1);
    @(negedge clk);
    lookup1(3'd0, 0, 1'b1);
    lookup1(3'd3, 0, 1'b0);

    // Randomised loads with back-to-back lookups and vector traffic.
    for (int k = 0; k < 6; k++) begin
      vm_t = 24'($urandom);
      do_load(N'($urandom), vm_t);
      run_lookups(12);
      run_vectors(6);
    end

    // Reset mid-build.
    vm_t = '0; vm_t[0] = 3'd4; vm_t[1] = 3'd4;
    for (int p = 2; p < N; p++) vm_t[p] = 3'(p - 2);
    fuse_map = 8'hFF; vid_map = vm_t; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("midbuild_busy", {31'b0, cfg_busy}, 1);
    chk("midbuild_err", {31'b0, cfg_err}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, cfg_busy}, 0);
    chk("async_rst_err", {31'b0, cfg_err}, 0);
    chk("async_rst_ready", {31'b0, req_ready}, 0);
    chk("async_rst_done", {31'b0, cfg_done}, 0);
    chk("async_rst_rsp", {28'b0, rsp_valid, rsp_mapped, rsp_vid}, 0);
    chk("async_rst_vec", {24'b0, vid_vector}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 1'b1; req_pid = 3'd2;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 0);
    chk("post_rst_busy", {31'b0, cfg_busy}, 0);
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("post_rst_vec", {24'b0, vid_vector}, 0);
    req_valid = 1'b0;
    vm_t = 24'($urandom);
    do_load(N'($urandom), vm_t);
    run_lookups(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
